// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared types and helpers for the radix-4 Booth controller
package booth4_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_OP    = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ADD_M  = 3'd1,
    OP_ADD_2M = 3'd2,
    OP_SUB_M  = 3'd3,
    OP_SUB_2M = 3'd4
  } booth_op_t;

  typedef struct packed {
    logic carga_a;
    logic mom2;
    logic resta;
  } op_ctl_t;

  // NOP leaves the mux and adder mode at 0 so they never toggle without a load.
  function automatic op_ctl_t op_to_ctl(input booth_op_t op);
    op_ctl_t c;
    c = '0;
    case (op)
      OP_ADD_M:  c = '{carga_a: 1'b1, mom2: 1'b0, resta: 1'b0};
      OP_ADD_2M: c = '{carga_a: 1'b1, mom2: 1'b1, resta: 1'b0};
      OP_SUB_M:  c = '{carga_a: 1'b1, mom2: 1'b0, resta: 1'b1};
      OP_SUB_2M: c = '{carga_a: 1'b1, mom2: 1'b1, resta: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth4_decode.sv
// rtl/booth4_decode.sv - Booth triplet {q1,q0,q-1} to operation code
module booth4_decode
  import booth4_pkg::*;
(
  input  logic      i_q1,
  input  logic      i_q0,
  input  logic      i_q_menos1,
  output booth_op_t o_op
);

  always_comb begin
    o_op = OP_NOP;
    case ({i_q1, i_q0, i_q_menos1})
      3'b001, 3'b010: o_op = OP_ADD_M;
      3'b011:         o_op = OP_ADD_2M;
      3'b100:         o_op = OP_SUB_2M;
      3'b101, 3'b110: o_op = OP_SUB_M;
      default:        o_op = OP_NOP;
    endcase
  end

endmodule

// File: rtl/uc_booth4.sv
// rtl/uc_booth4.sv - control unit sequencing the radix-4 Booth multiplier datapath
module uc_booth4
  import booth4_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q1,
  input  logic q0,
  input  logic q_menos1,
  output logic Clear_DP,
  output logic Carga_QM,
  output logic Carga_A,
  output logic Desplaza_AQ,
  output logic MoM2,
  output logic Resta,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(SIZE / 2 + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_clear;
  logic            r_carga_qm;
  logic            r_desp;
  logic            r_busy;
  logic            r_done;

  booth_op_t       w_op;
  op_ctl_t         w_ctl;
  logic            w_in_op;

  booth4_decode u_decode (
    .i_q1       (q1),
    .i_q0       (q0),
    .i_q_menos1 (q_menos1),
    .o_op       (w_op)
  );

  // Add/sub steering is the only Mealy path; gated by OP so it is 0 elsewhere and in reset.
  assign w_ctl   = op_to_ctl(w_op);
  assign w_in_op = (r_state == S_OP);

  assign Carga_A     = w_in_op & w_ctl.carga_a;
  assign MoM2        = w_in_op & w_ctl.mom2;
  assign Resta       = w_in_op & w_ctl.resta;
  assign Clear_DP    = r_clear;
  assign Carga_QM    = r_carga_qm;
  assign Desplaza_AQ = r_desp;
  assign busy        = r_busy;
  assign done        = r_done;

  // Moore outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clear    <= 1'b0;
      r_carga_qm <= 1'b0;
      r_desp     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clear    <= 1'b0;
      r_carga_qm <= 1'b0;
      r_desp     <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLEAR;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt      <= CW'(SIZE / 2);
          r_state    <= S_LOAD;
          r_carga_qm <= 1'b1;
        end
        S_LOAD: begin
          r_state <= S_OP;
        end
        S_OP: begin
          r_state <= S_SHIFT;
          r_desp  <= 1'b1;
        end
        S_SHIFT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_OP;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_booth4.sv
// tb/tb_uc_booth4.sv - scoreboard bench for uc_booth4 with a behavioural datapath
module tb_uc_booth4;

  localparam int SIZE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic q1, q0, q_menos1;
  logic Clear_DP, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int free_cyc = 0;

  typedef struct {
    logic [7:0] prod;
    int         done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_ctl[int];

  logic [3:0] op_m = 4'd0;
  logic [3:0] op_q = 4'd0;

  logic signed [5:0] dp_a;
  logic [3:0]        dp_q;
  logic [3:0]        dp_m;
  logic              dp_qm1;
  logic signed [5:0] w_m6;
  logic signed [5:0] w_opd;
  logic signed [9:0] w_sh;

  uc_booth4 #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .q1          (q1),
    .q0          (q0),
    .q_menos1    (q_menos1),
    .Clear_DP    (Clear_DP),
    .Carga_QM    (Carga_QM),
    .Carga_A     (Carga_A),
    .Desplaza_AQ (Desplaza_AQ),
    .MoM2        (MoM2),
    .Resta       (Resta),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Datapath: M, A, Q, q-1 with add/sub of M or 2M and arithmetic 2-bit shift.
  assign q1       = dp_q[1];
  assign q0       = dp_q[0];
  assign q_menos1 = dp_qm1;
  assign w_m6     = {{2{dp_m[3]}}, dp_m};
  assign w_opd    = MoM2 ? (w_m6 <<< 1) : w_m6;
  assign w_sh     = $signed({dp_a, dp_q}) >>> 2;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_qm1 <= 1'b0;
    end else if (Clear_DP) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_qm1 <= 1'b0;
    end else if (Carga_QM) begin
      dp_m <= op_m;
      dp_q <= op_q;
    end else if (Carga_A) begin
      dp_a <= Resta ? (dp_a - w_opd) : (dp_a + w_opd);
    end else if (Desplaza_AQ) begin
      dp_a   <= w_sh[9:4];
      dp_q   <= w_sh[3:0];
      dp_qm1 <= dp_q[1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Radix-4 digit value -> {Carga_A, MoM2, Resta}.
  function automatic logic [2:0] ctl_for_digit(input int d);
    logic [2:0] c;
    c[2] = (d != 0);
    c[1] = (d == 2) || (d == -2);
    c[0] = (d < 0);
    return c;
  endfunction

  // Reference model: accepts start when idle, predicts product, done cycle and per-cycle controls.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset && start && cyc >= free_cyc) begin
        int e, pm, d, lo;
        logic [2:0] c;
        logic [3:0] qv;
        e  = cyc;
        free_cyc = e + 8;
        pm = int'($signed(op_m)) * int'($signed(op_q));
        sb_q.push_back('{prod: pm[7:0], done_cyc: e + 6});
        qv = op_q;
        exp_ctl[e]     = 8'b1000_0010;
        exp_ctl[e + 1] = 8'b0100_0010;
        for (int i = 0; i < SIZE / 2; i++) begin
          lo = (i == 0) ? 0 : int'(qv[2*i-1]);
          d  = -2 * int'(qv[2*i+1]) + int'(qv[2*i]) + lo;
          c  = ctl_for_digit(d);
          exp_ctl[e + 2 + 2*i] = {2'b00, c[2], 1'b0, c[1], c[0], 2'b10};
          exp_ctl[e + 3 + 2*i] = 8'b0001_0010;
        end
        exp_ctl[e + 6] = 8'b0000_0011;
      end
    end
  end

  // Monitor: per-cycle control check plus scoreboard pop on done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        logic [7:0] act, req;
        exp_t x;
        act = {Clear_DP, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done};
        if (exp_ctl.exists(cyc)) begin
          req = exp_ctl[cyc];
          exp_ctl.delete(cyc);
        end else begin
          req = 8'h00;
        end
        chk("ctl", 32'(act), 32'(req));
        chk("ctl_onehot", 32'($countones({Clear_DP, Carga_QM, Carga_A, Desplaza_AQ}) <= 1), 32'd1);
        chk("mux_without_load", 32'(!Carga_A && (MoM2 || Resta)), 32'd0);
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            x = sb_q.pop_front();
            chk("done_cyc", 32'(cyc), 32'(x.done_cyc));
            chk("result", 32'({dp_a[3:0], dp_q}), 32'(x.prod));
          end
        end
      end
    end
  end

  task automatic run_op(input int m, input int q);
    while (cyc + 1 < free_cyc) @(negedge clk);
    op_m  = 4'(m);
    op_q  = 4'(q);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1;
    chk("reset_outputs", 32'({Clear_DP, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_op(3, 5);
    run_op(-8, 7);
    run_op(-8, -8);

    // start pulsed mid-operation must be ignored
    run_op(3, 5);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // start held high: back-to-back operations
    while (cyc + 1 < free_cyc) @(negedge clk);
    op_m  = 4'd2;
    op_q  = 4'hD;
    start = 1'b1;
    repeat (24) @(negedge clk);
    start = 1'b0;

    // asynchronous reset mid-SHIFT
    run_op(5, 6);
    repeat (3) @(negedge clk);
    chk("pre_reset_shift", 32'(Desplaza_AQ), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({Clear_DP, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done}), 32'd0);
    sb_q.delete();
    exp_ctl.delete();
    free_cyc = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    for (int m = 0; m < 16; m++)
      for (int q = 0; q < 16; q++)
        run_op(m, q);

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    repeat (12) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("controls_drained", 32'(exp_ctl.num()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_booth4.md
# uc_booth4

Control unit that sequences the radix-4 Booth multiplier datapath (registers M, 2M, A, Q, q₋₁ and the add/subtract unit). On a `start` request it clears and loads the datapath, then runs SIZE/2 evaluate/shift iterations, steering the M/2M selector and add/subtract mode from the Booth triplet `{q1, q0, q_menos1}`. It signals completion with a one-cycle `done` pulse, when the datapath `result` is valid. It sits beside the datapath in the multiplier top level and is its only source of control.

## Interface
- `SIZE`, default 4: operand width, matching the datapath; must be even and ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiplication; sampled only in IDLE.
- `q1`, `q0`, `q_menos1`  in  1 each: Booth triplet from the datapath.
- `Clear_DP`  out  1: datapath clear; the top level forms datapath reset = `reset & ~Clear_DP`.
- `Carga_QM`  out  1: load the multiplicand into M/2M and the multiplier into Q.
- `Carga_A`  out  1: load the adder output into A.
- `Desplaza_AQ`  out  1: arithmetic 2-bit right shift of A:Q and update of q₋₁.
- `MoM2`  out  1: operand select; 0 selects M, 1 selects 2M.
- `Resta`  out  1: adder mode; 0 adds, 1 subtracts.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.

## Operation
- States: IDLE, CLEAR, LOAD, OP, SHIFT, DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 → CLEAR.
- CLEAR:
  - `Clear_DP`=1.
  - Iteration counter ← SIZE/2.
  - → LOAD.
- LOAD: `Carga_QM`=1 → OP.
- OP: decode `{q1,q0,q_menos1}`:
  - 000 or 111: no load (`Carga_A`=0).
  - 001 or 010: +M (`Carga_A`=1, `MoM2`=0, `Resta`=0).
  - 011: +2M (`Carga_A`=1, `MoM2`=1, `Resta`=0).
  - 100: −2M (`Carga_A`=1, `MoM2`=1, `Resta`=1).
  - 101 or 110: −M (`Carga_A`=1, `MoM2`=0, `Resta`=1).
  - Always → SHIFT.
- SHIFT:
  - `Desplaza_AQ`=1; counter decrements.
  - If the counter was 1 → DONE; otherwise → OP.
- DONE: `done`=1 → IDLE.
- `MoM2` and `Resta` are 0 in every state other than OP, and in OP whenever `Carga_A`=0.
- At most one of `Clear_DP`, `Carga_QM`, `Carga_A`, `Desplaza_AQ` is high in any cycle.
- Counter width: $clog2(SIZE/2+1); it never wraps.
- `start` while `busy` is ignored and not queued. `start` held high through DONE starts a new operation from IDLE on the following cycle.

## Timing
- Reset is asynchronous: state → IDLE, counter → 0, every output → 0, including during a running operation. The datapath is not cleared by the controller until the next CLEAR.
- Outputs are Moore, except `Carga_A`, `MoM2` and `Resta` in OP, which are combinational from the triplet. The triplet is registered in the datapath and stable throughout OP.
- Latency from the cycle `start` is sampled to the `done` cycle: SIZE+3 cycles (CLEAR, LOAD, SIZE/2×(OP,SHIFT), DONE). For SIZE=4, `done` is high 7 cycles after start is sampled.
- Fixed latency: it is independent of the operand values.
- `result` stays valid from the `done` cycle until the next CLEAR.

## Structure
- Shared package `booth4_pkg`:
  - state enumeration and encoding;
  - Booth operation codes (NOP, ADD_M, ADD_2M, SUB_M, SUB_2M);
  - a function mapping an operation code to the `{Carga_A, MoM2, Resta}` triple.
- One natural sub-module, `booth4_decode`: combinational mapping of the triplet to the operation code, reusable by the bench scoreboard.
- The FSM and the counter live in `uc_booth4`.

## Test plan
- Reset asserted mid-SHIFT → all outputs 0 immediately, with no clock edge needed; after release the block is idle, `busy`=0.
- SIZE=4, M=3, Q=5 → OP decodes +M, +M; `done` at cycle 7; `result`=8'h0F.
- M=−8, Q=7 → OP decodes −M then +2M; `result`=8'hC8 (−56).
- M=−8, Q=−8 → OP decodes NOP then −2M (`Carga_A`=0 in the first OP); `result`=8'h40.
- `start` pulsed during OP → ignored: single `done`, latency unchanged. `start` held high → back-to-back operations with `done` every 8 cycles (7 + 1 in IDLE).
- Exhaustive SIZE=4 sweep of all 256 operand pairs against a signed product model. Each cycle also checks control one-hot-ness and that `MoM2`/`Resta` are 0 whenever `Carga_A`=0.
